alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_arbiter_if.sv | 54 +++++
 rtl/alu_arbiter_rr_arbiter_2.sv | 28 ++
 rtl/alu_arbiter.sv | 111 +++++++++++
 tb/tb_alu_arbiter.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU request arbiter: widths, ALU opcodes, FSM states.
package alu_pkg;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned OP_W    = 4;
   localparam int unsigned SHAMT_W = 5;

   localparam logic [OP_W-1:0] OP_NOP = 4'b0000;
   localparam logic [OP_W-1:0] OP_ORI = 4'b0001;
   localparam logic [OP_W-1:0] OP_SLL = 4'b0010;
   localparam logic [OP_W-1:0] OP_ADD = 4'b0011;
   localparam logic [OP_W-1:0] OP_SUB = 4'b0100;
   localparam logic [OP_W-1:0] OP_SRL = 4'b0101;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   typedef struct packed {
      logic [OP_W-1:0]    op;
      logic [DATA_W-1:0]  a;
      logic [DATA_W-1:0]  b;
      logic [SHAMT_W-1:0] shamt;
   } alu_req_t;

   function automatic logic op_known(input logic [OP_W-1:0] op);
      return (op == OP_ADD) || (op == OP_ORI) || (op == OP_SLL) ||
             (op == OP_SUB) || (op == OP_SRL);
   endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester, response and shared-ALU signals of the arbiter; slave = arbiter side.
interface alu_arbiter_if;
   import alu_pkg::*;

   logic               req0_valid_i, req1_valid_i;
   logic [OP_W-1:0]    req0_op_i, req1_op_i;
   logic [DATA_W-1:0]  req0_a_i, req1_a_i;
   logic [DATA_W-1:0]  req0_b_i, req1_b_i;
   logic [SHAMT_W-1:0] req0_shamt_i, req1_shamt_i;
   logic               req0_ready_o, req1_ready_o;

   logic               rsp0_valid_o, rsp1_valid_o;
   logic [DATA_W-1:0]  rsp0_data_o, rsp1_data_o;
   logic               rsp0_zero_o, rsp1_zero_o;
   logic               rsp0_ready_i, rsp1_ready_i;
`ifdef ALU_ARB_OPCHECK_EN
   logic               rsp0_err_o, rsp1_err_o;
`endif

   logic [OP_W-1:0]    alu_operation_o;
   logic [DATA_W-1:0]  alu_a_o, alu_b_o;
   logic [SHAMT_W-1:0] alu_shamt_o;
   logic [DATA_W-1:0]  alu_data_i;
   logic               alu_zero_i;

   modport slave (
      input  req0_valid_i, req0_op_i, req0_a_i, req0_b_i, req0_shamt_i,
      input  req1_valid_i, req1_op_i, req1_a_i, req1_b_i, req1_shamt_i,
      output req0_ready_o, req1_ready_o,
      output rsp0_valid_o, rsp0_data_o, rsp0_zero_o,
      output rsp1_valid_o, rsp1_data_o, rsp1_zero_o,
`ifdef ALU_ARB_OPCHECK_EN
      output rsp0_err_o, rsp1_err_o,
`endif
      input  rsp0_ready_i, rsp1_ready_i,
      output alu_operation_o, alu_a_o, alu_b_o, alu_shamt_o,
      input  alu_data_i, alu_zero_i
   );

   modport master (
      output req0_valid_i, req0_op_i, req0_a_i, req0_b_i, req0_shamt_i,
      output req1_valid_i, req1_op_i, req1_a_i, req1_b_i, req1_shamt_i,
      input  req0_ready_o, req1_ready_o,
      input  rsp0_valid_o, rsp0_data_o, rsp0_zero_o,
      input  rsp1_valid_o, rsp1_data_o, rsp1_zero_o,
`ifdef ALU_ARB_OPCHECK_EN
      input  rsp0_err_o, rsp1_err_o,
`endif
      output rsp0_ready_i, rsp1_ready_i,
      input  alu_operation_o, alu_a_o, alu_b_o, alu_shamt_o,
      output alu_data_i, alu_zero_i
   );

endinterface

// File: rtl/alu_arbiter_rr_arbiter_2.sv
// Two-way round-robin arbiter: one-hot combinational grant, pointer moves on each grant.
module rr_arbiter_2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   output logic [1:0] grant
);

   logic prio_q; // 1: requester 1 wins a tie

   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = prio_q ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         prio_q <= 1'b0;
      else if (|grant)
         prio_q <= grant[0];
   end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU, one op in flight.
// Optional macro ALU_ARB_OPCHECK_EN answers unknown opcodes with an error response.
module alu_arbiter
   import alu_pkg::*;
(
   input logic          clk,
   input logic          reset,
   alu_arbiter_if.slave bus
);

   state_t            state, state_nxt;
   alu_req_t          req_q, req_sel;
   logic              owner_q;
   logic [DATA_W-1:0] data_q;
   logic              zero_q;
   logic              err_q;
   logic [1:0]        req_vec, grant;
   logic              accept, rsp_hs, bad_op;
   logic              resp0, resp1;

   // Requests are only visible to the arbiter in IDLE and outside reset.
   assign req_vec = {bus.req1_valid_i, bus.req0_valid_i} & {2{(state == ST_IDLE) && reset}};
   assign accept  = |grant;
   assign rsp_hs  = (state == ST_RESP) && (owner_q ? bus.rsp1_ready_i : bus.rsp0_ready_i);

   rr_arbiter_2 u_rr (
      .clk   (clk),
      .reset (reset),
      .req   (req_vec),
      .grant (grant)
   );

   always_comb begin
      if (grant[1]) begin
         req_sel.op    = bus.req1_op_i;
         req_sel.a     = bus.req1_a_i;
         req_sel.b     = bus.req1_b_i;
         req_sel.shamt = bus.req1_shamt_i;
      end else begin
         req_sel.op    = bus.req0_op_i;
         req_sel.a     = bus.req0_a_i;
         req_sel.b     = bus.req0_b_i;
         req_sel.shamt = bus.req0_shamt_i;
      end
   end

`ifdef ALU_ARB_OPCHECK_EN
   assign bad_op = !op_known(req_sel.op);
`else
   assign bad_op = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (accept) state_nxt = bad_op ? ST_RESP : ST_ISSUE;
         ST_ISSUE: state_nxt = ST_RESP;
         ST_RESP:  if (rsp_hs) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Rejected opcodes get their 0 / zero=1 result at acceptance; ISSUE overwrites otherwise.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         req_q   <= '0;
         owner_q <= 1'b0;
         data_q  <= '0;
         zero_q  <= 1'b0;
         err_q   <= 1'b0;
      end else if (accept) begin
         req_q   <= req_sel;
         owner_q <= grant[1];
         data_q  <= '0;
         zero_q  <= bad_op;
         err_q   <= bad_op;
      end else if (state == ST_ISSUE) begin
         data_q  <= bus.alu_data_i;
         zero_q  <= bus.alu_zero_i;
      end
   end

   always_comb begin
      resp0               = (state == ST_RESP) && !owner_q;
      resp1               = (state == ST_RESP) && owner_q;
      bus.req0_ready_o    = grant[0];
      bus.req1_ready_o    = grant[1];
      bus.rsp0_valid_o    = resp0;
      bus.rsp1_valid_o    = resp1;
      bus.rsp0_data_o     = data_q;
      bus.rsp1_data_o     = data_q;
      bus.rsp0_zero_o     = zero_q;
      bus.rsp1_zero_o     = zero_q;
`ifdef ALU_ARB_OPCHECK_EN
      bus.rsp0_err_o      = resp0 && err_q;
      bus.rsp1_err_o      = resp1 && err_q;
`endif
      bus.alu_operation_o = (state == ST_ISSUE) ? req_q.op : OP_NOP;
      bus.alu_a_o         = req_q.a;
      bus.alu_b_o         = req_q.b;
      bus.alu_shamt_o     = req_q.shamt;
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU closing the loop.
module tb_alu_arbiter;

   logic clk;
   logic reset;
   int   checks;
   int   failures;
   logic [31:0] alu_res;

   alu_arbiter_if bus ();

   alu_arbiter u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      case (bus.alu_operation_o)
         4'b0011: alu_res = bus.alu_a_o + bus.alu_b_o;
         4'b0001: alu_res = bus.alu_a_o | bus.alu_b_o;
         4'b0010: alu_res = bus.alu_b_o << bus.alu_shamt_o;
         4'b0100: alu_res = bus.alu_a_o - bus.alu_b_o;
         4'b0101: alu_res = bus.alu_b_o >> bus.alu_shamt_o;
         default: alu_res = 32'h0;
      endcase
   end
   assign bus.alu_data_i = alu_res;
   assign bus.alu_zero_i = (alu_res == 32'h0);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int n, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh);
      if (n == 0) begin
         bus.req0_valid_i = 1'b1; bus.req0_op_i = op; bus.req0_a_i = a;
         bus.req0_b_i = b; bus.req0_shamt_i = sh;
      end else begin
         bus.req1_valid_i = 1'b1; bus.req1_op_i = op; bus.req1_a_i = a;
         bus.req1_b_i = b; bus.req1_shamt_i = sh;
      end
   endtask

   task automatic clr_req();
      bus.req0_valid_i = 1'b0;
      bus.req1_valid_i = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      clr_req();
      bus.req0_op_i = '0; bus.req0_a_i = '0; bus.req0_b_i = '0; bus.req0_shamt_i = '0;
      bus.req1_op_i = '0; bus.req1_a_i = '0; bus.req1_b_i = '0; bus.req1_shamt_i = '0;
      bus.rsp0_ready_i = 1'b0;
      bus.rsp1_ready_i = 1'b0;
      tick();
      set_req(0, 4'b0011, 32'd1, 32'd1, 5'd0);
      #1;
      checks++; if (bus.req0_ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready0 got=%0b exp=0", bus.req0_ready_o); end
      tick();
      checks++; if (bus.rsp0_valid_o !== 1'b0 || bus.rsp1_valid_o !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%0b%0b exp=00", bus.rsp1_valid_o, bus.rsp0_valid_o); end
      checks++; if (bus.alu_operation_o !== 4'h0) begin failures++; $display("FAIL reset_alu_op got=%h exp=0", bus.alu_operation_o); end
      checks++; if (bus.alu_a_o !== 32'h0 || bus.alu_b_o !== 32'h0 || bus.alu_shamt_o !== 5'h0) begin failures++; $display("FAIL reset_alu_operands got=%h/%h/%h exp=0/0/0", bus.alu_a_o, bus.alu_b_o, bus.alu_shamt_o); end
      checks++; if (bus.rsp0_data_o !== 32'h0 || bus.rsp0_zero_o !== 1'b0) begin failures++; $display("FAIL reset_rsp_data got=%h/%0b exp=0/0", bus.rsp0_data_o, bus.rsp0_zero_o); end
      clr_req();
      reset = 1'b1;
   endtask

   task automatic test_contention();
      set_req(0, 4'b0011, 32'd1, 32'd2, 5'd0);
      set_req(1, 4'b0001, 32'h0000_00F0, 32'h0000_000F, 5'd0);
      #1;
      checks++; if (bus.req0_ready_o !== 1'b1 || bus.req1_ready_o !== 1'b0) begin failures++; $display("FAIL cont_first_grant got=%0b%0b exp=01", bus.req1_ready_o, bus.req0_ready_o); end
      tick();
      checks++; if (bus.alu_operation_o !== 4'b0011 || bus.req1_ready_o !== 1'b0) begin failures++; $display("FAIL cont_issue0 op=%h rdy1=%0b exp=3/0", bus.alu_operation_o, bus.req1_ready_o); end
      tick();
      checks++; if (bus.rsp0_valid_o !== 1'b1 || bus.rsp0_data_o !== 32'd3 || bus.rsp1_valid_o !== 1'b0) begin failures++; $display("FAIL cont_rsp0 v=%0b d=%h v1=%0b exp=1/3/0", bus.rsp0_valid_o, bus.rsp0_data_o, bus.rsp1_valid_o); end
      bus.rsp0_ready_i = 1'b1;
      tick();
      bus.rsp0_ready_i = 1'b0;
      checks++; if (bus.req1_ready_o !== 1'b1 || bus.req0_ready_o !== 1'b0) begin failures++; $display("FAIL cont_second_grant got=%0b%0b exp=10", bus.req1_ready_o, bus.req0_ready_o); end
      tick();
      clr_req();
      checks++; if (bus.alu_operation_o !== 4'b0001) begin failures++; $display("FAIL cont_issue1 op=%h exp=1", bus.alu_operation_o); end
      tick();
      checks++; if (bus.rsp1_valid_o !== 1'b1 || bus.rsp1_data_o !== 32'hFF || bus.rsp1_zero_o !== 1'b0) begin failures++; $display("FAIL cont_rsp1 v=%0b d=%h z=%0b exp=1/ff/0", bus.rsp1_valid_o, bus.rsp1_data_o, bus.rsp1_zero_o); end
      bus.rsp1_ready_i = 1'b1;
      tick();
      bus.rsp1_ready_i = 1'b0;
      checks++; if (bus.rsp1_valid_o !== 1'b0) begin failures++; $display("FAIL cont_rsp1_done got=%0b exp=0", bus.rsp1_valid_o); end
   endtask

   task automatic test_single();
      set_req(0, 4'b0011, 32'd5, 32'd7, 5'd0);
      #1;
      checks++; if (bus.req0_ready_o !== 1'b1) begin failures++; $display("FAIL single_accept got=%0b exp=1", bus.req0_ready_o); end
      tick();
      clr_req();
      checks++; if (bus.alu_operation_o !== 4'b0011 || bus.alu_a_o !== 32'd5 || bus.alu_b_o !== 32'd7) begin failures++; $display("FAIL single_issue op=%h a=%h b=%h exp=3/5/7", bus.alu_operation_o, bus.alu_a_o, bus.alu_b_o); end
      checks++; if (bus.rsp0_valid_o !== 1'b0) begin failures++; $display("FAIL single_early_rsp got=%0b exp=0", bus.rsp0_valid_o); end
      tick();
      checks++; if (bus.rsp0_valid_o !== 1'b1 || bus.rsp0_data_o !== 32'd12 || bus.rsp0_zero_o !== 1'b0) begin failures++; $display("FAIL single_rsp v=%0b d=%h z=%0b exp=1/c/0", bus.rsp0_valid_o, bus.rsp0_data_o, bus.rsp0_zero_o); end
      checks++; if (bus.alu_operation_o !== 4'h0 || bus.alu_a_o !== 32'd5) begin failures++; $display("FAIL single_alu_idle op=%h a=%h exp=0/5", bus.alu_operation_o, bus.alu_a_o); end
      bus.rsp0_ready_i = 1'b1;
      tick();
      bus.rsp0_ready_i = 1'b0;
      checks++; if (bus.rsp0_valid_o !== 1'b0) begin failures++; $display("FAIL single_rsp_done got=%0b exp=0", bus.rsp0_valid_o); end
   endtask

   task automatic test_back_to_back();
      set_req(1, 4'b0100, 32'd9, 32'd9, 5'd0);
      #1;
      checks++; if (bus.req1_ready_o !== 1'b1) begin failures++; $display("FAIL bp_accept got=%0b exp=1", bus.req1_ready_o); end
      tick();
      clr_req();
      tick();
      set_req(0, 4'b0011, 32'd1, 32'd1, 5'd0);
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++; if (bus.rsp1_valid_o !== 1'b1 || bus.rsp1_data_o !== 32'h0 || bus.rsp1_zero_o !== 1'b1) begin failures++; $display("FAIL bp_hold%0d v=%0b d=%h z=%0b exp=1/0/1", i, bus.rsp1_valid_o, bus.rsp1_data_o, bus.rsp1_zero_o); end
         checks++; if (bus.req0_ready_o !== 1'b0) begin failures++; $display("FAIL bp_no_accept%0d got=%0b exp=0", i, bus.req0_ready_o); end
         tick();
      end
      bus.rsp1_ready_i = 1'b1;
      tick();
      bus.rsp1_ready_i = 1'b0;
      checks++; if (bus.rsp1_valid_o !== 1'b0 || bus.req0_ready_o !== 1'b1) begin failures++; $display("FAIL bp_release v1=%0b rdy0=%0b exp=0/1", bus.rsp1_valid_o, bus.req0_ready_o); end
      clr_req();
   endtask

   task automatic test_shift();
      set_req(1, 4'b0010, 32'd0, 32'd1, 5'd31);
      tick();
      clr_req();
      checks++; if (bus.alu_operation_o !== 4'b0010 || bus.alu_shamt_o !== 5'd31) begin failures++; $display("FAIL sll_issue op=%h sh=%0d exp=2/31", bus.alu_operation_o, bus.alu_shamt_o); end
      tick();
      checks++; if (bus.rsp1_valid_o !== 1'b1 || bus.rsp1_data_o !== 32'h8000_0000 || bus.rsp1_zero_o !== 1'b0) begin failures++; $display("FAIL sll_rsp v=%0b d=%h z=%0b exp=1/80000000/0", bus.rsp1_valid_o, bus.rsp1_data_o, bus.rsp1_zero_o); end
      bus.rsp1_ready_i = 1'b1;
      tick();
      bus.rsp1_ready_i = 1'b0;
      set_req(1, 4'b0101, 32'd0, 32'h8000_0000, 5'd31);
      tick();
      clr_req();
      tick();
      checks++; if (bus.rsp1_valid_o !== 1'b1 || bus.rsp1_data_o !== 32'h1) begin failures++; $display("FAIL srl_rsp v=%0b d=%h exp=1/1", bus.rsp1_valid_o, bus.rsp1_data_o); end
      bus.rsp1_ready_i = 1'b1;
      tick();
      bus.rsp1_ready_i = 1'b0;
      checks++; if (bus.alu_operation_o !== 4'h0 || bus.alu_b_o !== 32'h8000_0000 || bus.alu_shamt_o !== 5'd31) begin failures++; $display("FAIL shift_hold op=%h b=%h sh=%0d exp=0/80000000/31", bus.alu_operation_o, bus.alu_b_o, bus.alu_shamt_o); end
   endtask

   task automatic test_withdraw();
      set_req(0, 4'b0011, 32'd6, 32'd6, 5'd0);
      #1;
      checks++; if (bus.req0_ready_o !== 1'b1) begin failures++; $display("FAIL wd_ready got=%0b exp=1", bus.req0_ready_o); end
      clr_req();
      tick();
      checks++; if (bus.alu_operation_o !== 4'h0 || bus.rsp0_valid_o !== 1'b0) begin failures++; $display("FAIL wd_ignored op=%h v=%0b exp=0/0", bus.alu_operation_o, bus.rsp0_valid_o); end
      tick();
      checks++; if (bus.rsp0_valid_o !== 1'b0 || bus.alu_b_o !== 32'h8000_0000) begin failures++; $display("FAIL wd_no_state v=%0b b=%h exp=0/80000000", bus.rsp0_valid_o, bus.alu_b_o); end
   endtask

   task automatic test_reset_issue();
      set_req(0, 4'b0011, 32'd3, 32'd4, 5'd2);
      tick();
      clr_req();
      checks++; if (bus.alu_operation_o !== 4'b0011) begin failures++; $display("FAIL rst_issue_op got=%h exp=3", bus.alu_operation_o); end
      reset = 1'b0;
      #1;
      checks++; if (bus.alu_operation_o !== 4'h0 || bus.alu_a_o !== 32'h0 || bus.alu_b_o !== 32'h0 || bus.alu_shamt_o !== 5'h0) begin failures++; $display("FAIL rst_issue_alu op=%h a=%h b=%h sh=%h exp=0", bus.alu_operation_o, bus.alu_a_o, bus.alu_b_o, bus.alu_shamt_o); end
      checks++; if (bus.rsp0_valid_o !== 1'b0 || bus.rsp0_data_o !== 32'h0) begin failures++; $display("FAIL rst_issue_rsp v=%0b d=%h exp=0/0", bus.rsp0_valid_o, bus.rsp0_data_o); end
      tick();
      reset = 1'b1;
      tick();
      tick();
      checks++; if (bus.rsp0_valid_o !== 1'b0 || bus.rsp1_valid_o !== 1'b0 || bus.alu_operation_o !== 4'h0) begin failures++; $display("FAIL rst_no_rsp v=%0b%0b op=%h exp=00/0", bus.rsp1_valid_o, bus.rsp0_valid_o, bus.alu_operation_o); end
      set_req(0, 4'b0011, 32'd2, 32'd2, 5'd0);
      set_req(1, 4'b0011, 32'd8, 32'd8, 5'd0);
      #1;
      checks++; if (bus.req0_ready_o !== 1'b1 || bus.req1_ready_o !== 1'b0) begin failures++; $display("FAIL rst_prio got=%0b%0b exp=01", bus.req1_ready_o, bus.req0_ready_o); end
      tick();
      clr_req();
      tick();
      checks++; if (bus.rsp0_valid_o !== 1'b1 || bus.rsp0_data_o !== 32'd4) begin failures++; $display("FAIL rst_after_rsp v=%0b d=%h exp=1/4", bus.rsp0_valid_o, bus.rsp0_data_o); end
      bus.rsp0_ready_i = 1'b1;
      tick();
      bus.rsp0_ready_i = 1'b0;
   endtask

   task automatic test_illegal_op();
      set_req(0, 4'b1111, 32'd5, 32'd5, 5'd0);
      tick();
      clr_req();
`ifdef ALU_ARB_OPCHECK_EN
      checks++; if (bus.rsp0_valid_o !== 1'b1 || bus.rsp0_data_o !== 32'h0 || bus.rsp0_zero_o !== 1'b1 || bus.rsp0_err_o !== 1'b1) begin failures++; $display("FAIL opchk_rsp v=%0b d=%h z=%0b e=%0b exp=1/0/1/1", bus.rsp0_valid_o, bus.rsp0_data_o, bus.rsp0_zero_o, bus.rsp0_err_o); end
      checks++; if (bus.alu_operation_o !== 4'h0) begin failures++; $display("FAIL opchk_no_issue op=%h exp=0", bus.alu_operation_o); end
`else
      checks++; if (bus.alu_operation_o !== 4'b1111) begin failures++; $display("FAIL op15_issue op=%h exp=f", bus.alu_operation_o); end
      tick();
      checks++; if (bus.rsp0_valid_o !== 1'b1 || bus.rsp0_data_o !== 32'h0 || bus.rsp0_zero_o !== 1'b1) begin failures++; $display("FAIL op15_rsp v=%0b d=%h z=%0b exp=1/0/1", bus.rsp0_valid_o, bus.rsp0_data_o, bus.rsp0_zero_o); end
`endif
      bus.rsp0_ready_i = 1'b1;
      tick();
      bus.rsp0_ready_i = 1'b0;
      checks++; if (bus.rsp0_valid_o !== 1'b0) begin failures++; $display("FAIL op15_done got=%0b exp=0", bus.rsp0_valid_o); end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_contention();
      test_single();
      test_back_to_back();
      test_shift();
      test_withdraw();
      test_reset_issue();
      test_illegal_op();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
